// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: requester handshakes plus MAR/MDR/DRAM strobe bus of the memory sequencer
interface mem_access_ctrl_if #(
  parameter int AW = 18,
  parameter int DW = 9
);
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1, busy;
  logic [DW-1:0] rdata;
  logic          mar_write, mdr_write, dram_write;
  logic [AW:0]   mar_din;
  logic [DW-1:0] mdr_din, mdr_dout, dram_dout;
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mdr_dout, dram_dout,
    output ack0, ack1, rdata, busy, mar_write, mar_din, mdr_write, mdr_din, dram_write
  );
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mdr_dout, dram_dout,
    input  ack0, ack1, rdata, busy, mar_write, mar_din, mdr_write, mdr_din, dram_write
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: round-robin sequencer owning the MAR/MDR/DRAM write strobes
module mem_access_ctrl #(
  parameter int AW      = 18,
  parameter int DW      = 9,
  parameter int RD_WAIT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_access_ctrl_if.slave    bus
);
  typedef enum logic [2:0] {IDLE, ADDR, RWAIT, CAP, WR, ACK} state_t;
  state_t        state;
  logic [3:0]    cnt;
  logic          last, gnt, we_q, pick;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  assign pick = (bus.req0 && bus.req1) ? ~last : bus.req1;
  // State sequencing, round-robin grant and request capture (ports only sampled in IDLE)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      last    <= 1'b1;
      gnt     <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state)
        IDLE: if (bus.req0 || bus.req1) begin
          state   <= ADDR;
          gnt     <= pick;
          last    <= pick;
          we_q    <= pick ? bus.we1 : bus.we0;
          addr_q  <= pick ? bus.addr1 : bus.addr0;
          wdata_q <= pick ? bus.wdata1 : bus.wdata0;
        end
        ADDR: begin
          state <= we_q ? WR : (RD_WAIT > 0 ? RWAIT : CAP);
          cnt   <= 4'(RD_WAIT - 1);
        end
        RWAIT: if (cnt == 4'd0) state <= CAP; else cnt <= cnt - 4'd1;
        CAP, WR: state <= ACK;
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.busy       = state != IDLE;
  assign bus.mar_write  = state == ADDR;
  assign bus.mar_din    = {1'b0, addr_q};
  assign bus.mdr_write  = (state == ADDR && we_q) || state == CAP;
  assign bus.mdr_din    = state == CAP ? bus.dram_dout : wdata_q;
  assign bus.dram_write = state == WR;
  assign bus.ack0       = state == ACK && !gnt;
  assign bus.ack1       = state == ACK && gnt;
  assign bus.rdata      = state == ACK ? bus.mdr_dout : '0;
endmodule
